core_addr_sequencer: RTL

- Upstream feeder for the Core block: generates Core's `en` and 11-bit `addr` inputs.
- Steps `addr` through a programmed range [base_addr .. last_addr] at a programmable rate, with optional looping.
- Start/busy/done handshake towards the controlling logic, plus an abort input.
- Replaces hand-driven address stimulus with a synthesizable playback controller.

---
 rtl/core_pkg.sv | 20 ++
 rtl/core_rate_div.sv | 34 +++
 rtl/core_addr_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared constants and state encoding for the Core address sequencer.
// Both the sequencer top and its rate divider import this package.
package core_pkg;

  localparam int ADDR_W = 11;
  localparam int DIV_W  = 16;

  // 2'd3 is unused and recovers to IDLE in the FSM.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Reload value for the divider: a programmed rate of 0 behaves like 1.
  function automatic logic [DIV_W-1:0] div_period_m1(input logic [DIV_W-1:0] rate);
    return (rate == '0) ? '0 : rate - 1'b1;
  endfunction

endpackage

// File: rtl/core_rate_div.sv
// Loadable down-counter that ticks once every (period_m1 + 1) enabled cycles.
// The tick marks the last cycle of the current address hold period.
module core_rate_div
  import core_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_period_m1,
  input  logic             i_en,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] r_reload;

  // NOTE: sequential state uses non-blocking assignments only, and the
  // synchronous reset sits inside the clocked block as the first branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_reload <= '0;
    end else if (i_load) begin
      r_count  <= i_period_m1;
      r_reload <= i_period_m1;
    end else if (i_en) begin
      if (r_count == '0) r_count <= r_reload;
      else               r_count <= r_count - 1'b1;
    end
  end

  assign o_tick = i_en && (r_count == '0);

endmodule

// File: rtl/core_addr_sequencer.sv
// Playback controller driving Core's en/addr: steps a captured address range
// at a programmable rate, optionally looping, with start/busy/done handshake.
module core_addr_sequencer
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [DIV_W-1:0]  rate_div,
  output logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic              wrap
);

  state_t            r_state;
  logic              r_pend;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_last;
  logic              r_loop;
  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_wrap;

  logic              w_load;
  logic              w_run;
  logic              w_tick;
  logic [DIV_W-1:0]  w_period_m1;

  // Config is captured on the start edge; outputs go live one edge later.
  assign w_load      = (r_state == IDLE) && !r_pend && start;
  assign w_run       = (r_state == RUN);
  assign w_period_m1 = div_period_m1(rate_div);

  core_rate_div u_rate_div (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_period_m1 (w_period_m1),
    .i_en        (w_run),
    .o_tick      (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pend  <= 1'b0;
      r_base  <= '0;
      r_last  <= '0;
      r_loop  <= 1'b0;
      r_en    <= 1'b0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_pend) begin
            r_pend  <= 1'b0;
            r_addr  <= r_base;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else if (start) begin
            r_pend <= 1'b1;
            r_base <= base_addr;
            r_last <= last_addr;
            r_loop <= loop_en;
          end
        end
        RUN: begin
          if (stop) begin
            r_en    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FINISH;
          end else if (w_tick) begin
            if (r_addr == r_last) begin
              if (r_loop) begin
                r_addr <= r_base;
                r_wrap <= 1'b1;
              end else begin
                r_en    <= 1'b0;
                r_done  <= 1'b1;
                r_state <= FINISH;
              end
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        FINISH: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_pend  <= 1'b0;
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign en   = r_en;
  assign addr = r_addr;
  assign busy = r_busy;
  assign done = r_done;
  assign wrap = r_wrap;

endmodule
